fir_sm_fifo: RTL and testbench

- Output-side AXI-Stream buffer that sits directly downstream of the FIR engine's sm_* master port.
- Absorbs back-pressure from the consumer (DMA/testbench sink) so the FIR core is not stalled sample-by-sample.
- Carries tlast through unchanged.
- Checks that each frame's beat count matches the programmed data_length; flags frame completion and length mismatch.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_sm_len_chk.sv | 59 +++++
 rtl/fir_sm_fifo.sv | 117 +++++++++++
 tb/tb_fir_sm_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR-engine definitions: stream width, address width, default frame size,
// tap count and the packed {last,data} beat type.
package fir_pkg;

   localparam int DATA_W           = 32;
   localparam int ADDR_W           = 12;
   localparam int DEFAULT_DATA_NUM = 600;
   localparam int TAP_NUM          = 11;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } axis_beat_t;

endpackage

// File: rtl/fir_sm_len_chk.sv
// Frame-length checker for the FIR output stream. It counts accepted beats,
// latches the expected length on the first beat of a frame and raises a sticky mismatch flag.
module fir_sm_len_chk
   import fir_pkg::*;
#(
   parameter int pLEN_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_last,
   input  logic [pLEN_WIDTH-1:0] i_frame_len,
   input  logic                  i_err_clr,
   output logic                  o_len_err
);

   logic [pLEN_WIDTH-1:0] r_cnt;
   logic [pLEN_WIDTH-1:0] r_len;
   logic                  r_len_err;
   logic [pLEN_WIDTH-1:0] w_len_eff;
   logic [pLEN_WIDTH-1:0] w_cnt_p1;
   logic                  w_err_set;

   // The first beat of a frame compares against the live frame_len, because the latch loads on that same edge.
   always_comb begin
      w_len_eff = (r_cnt == '0) ? i_frame_len : r_len;
      w_cnt_p1  = r_cnt + pLEN_WIDTH'(1);
      w_err_set = 1'b0;
      if (i_push) begin
         if (w_len_eff == '0)
            w_err_set = 1'b1;
         else if (i_last)
            w_err_set = (w_cnt_p1 != w_len_eff);
         else
            w_err_set = (w_cnt_p1 == w_len_eff);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_len     <= '0;
         r_len_err <= 1'b0;
      end else begin
         if (i_push) begin
            if (r_cnt == '0)
               r_len <= i_frame_len;
            r_cnt <= i_last ? '0 : w_cnt_p1;
         end
         if (w_err_set)
            r_len_err <= 1'b1;
         else if (i_err_clr)
            r_len_err <= 1'b0;
      end
   end

   assign o_len_err = r_len_err;

endmodule

// File: rtl/fir_sm_fifo.sv
// First-word-fall-through AXI-Stream buffer behind the FIR sm_* port, with a frame-length check.
// Define FIR_SM_FIFO_PEAK_EN to add the peak_level occupancy high-water-mark output.
module fir_sm_fifo
   import fir_pkg::*;
#(
   parameter int pDATA_WIDTH = DATA_W,
   parameter int pDEPTH_LOG2 = 3,
   parameter int pLEN_WIDTH  = 32
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   s_tvalid,
   input  logic [pDATA_WIDTH-1:0] s_tdata,
   input  logic                   s_tlast,
   output logic                   s_tready,
   output logic                   m_tvalid,
   output logic [pDATA_WIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   input  logic                   m_tready,
   input  logic [pLEN_WIDTH-1:0]  frame_len,
   input  logic                   err_clr,
   output logic [pDEPTH_LOG2:0]   level,
   output logic                   frame_done,
   output logic                   len_err
`ifdef FIR_SM_FIFO_PEAK_EN
   ,
   output logic [pDEPTH_LOG2:0]   peak_level
`endif
);

   localparam int AW    = pDEPTH_LOG2;
   localparam int DEPTH = 1 << AW;

   logic [pDATA_WIDTH:0] r_mem [DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic                 r_s_tready;
   logic                 r_frame_done;

   logic [AW:0]          w_wr_ptr_next;
   logic [AW:0]          w_rd_ptr_next;
   logic [pDATA_WIDTH:0] w_rd_entry;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full_next;

   function automatic logic f_full(input logic [AW:0] wr, input logic [AW:0] rd);
      return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
   endfunction

   always_comb begin
      w_empty       = (r_wr_ptr == r_rd_ptr);
      w_push        = s_tvalid && r_s_tready;
      w_pop         = !w_empty && m_tready;
      w_wr_ptr_next = r_wr_ptr + (AW+1)'(w_push);
      w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_pop);
      w_full_next   = f_full(w_wr_ptr_next, w_rd_ptr_next);
      w_rd_entry    = r_mem[r_rd_ptr[AW-1:0]];
   end

   // Ready is registered from the next-state fullness, so m_tready never reaches s_tready combinationally.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_s_tready   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_ptr_next;
         r_rd_ptr     <= w_rd_ptr_next;
         r_s_tready   <= !w_full_next;
         r_frame_done <= w_pop && w_rd_entry[pDATA_WIDTH];
      end
   end

   always_ff @(posedge axis_clk) begin
      if (w_push)
         r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
   end

   // The output is forced to zero while empty, so stale or uninitialised storage never shows.
   assign s_tready   = r_s_tready;
   assign m_tvalid   = !w_empty;
   assign m_tdata    = w_empty ? '0 : w_rd_entry[pDATA_WIDTH-1:0];
   assign m_tlast    = w_empty ? 1'b0 : w_rd_entry[pDATA_WIDTH];
   assign level      = r_wr_ptr - r_rd_ptr;
   assign frame_done = r_frame_done;

   fir_sm_len_chk #(
      .pLEN_WIDTH (pLEN_WIDTH)
   ) u_len_chk (
      .clk         (axis_clk),
      .rst_n       (axis_rst_n),
      .i_push      (w_push),
      .i_last      (s_tlast),
      .i_frame_len (frame_len),
      .i_err_clr   (err_clr),
      .o_len_err   (len_err)
   );

`ifdef FIR_SM_FIFO_PEAK_EN
   logic [AW:0] r_peak_level;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n)
         r_peak_level <= '0;
      else if (err_clr)
         r_peak_level <= level;
      else if (level > r_peak_level)
         r_peak_level <= level;
   end

   assign peak_level = r_peak_level;
`endif

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Directed self-checking bench for fir_sm_fifo: streaming, backpressure, simultaneous
// push/pop, frame-length errors and mid-frame reset.
module tb_fir_sm_fifo;

   logic        axis_clk;
   logic        axis_rst_n;
   logic        s_tvalid;
   logic [31:0] s_tdata;
   logic        s_tlast;
   logic        s_tready;
   logic        m_tvalid;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic        m_tready;
   logic [31:0] frame_len;
   logic        err_clr;
   logic [3:0]  level;
   logic        frame_done;
   logic        len_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [32:0] rx_q [$];
   int          fd_cnt   = 0;
   int          rdy_drop = 0;
   bit          mon_rdy  = 0;

   fir_sm_fifo dut (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .s_tvalid   (s_tvalid),
      .s_tdata    (s_tdata),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .m_tvalid   (m_tvalid),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready),
      .frame_len  (frame_len),
      .err_clr    (err_clr),
      .level      (level),
      .frame_done (frame_done),
      .len_err    (len_err)
   );

   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   // Output monitor samples on the falling edge, away from the active edge.
   always @(negedge axis_clk) begin
      if (axis_rst_n) begin
         if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
         if (frame_done) fd_cnt++;
         if (mon_rdy && !s_tready) rdy_drop++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   // Holds one beat until accepted (bounded), returns at posedge+1 of the accepting edge.
   task automatic push(input logic [31:0] d, input logic l);
      logic rdy;
      int   n;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      n = 0;
      do begin
         @(negedge axis_clk);
         rdy = s_tready;
         tick();
         n++;
      end while (!rdy && n < 50);
      if (!rdy) chk("push_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   // Checks received beats from index base onward against values 1..cnt with tlast on the final beat.
   task automatic chk_rx(input string tag, input int base, input int cnt);
      chk({tag, "_count"}, rx_q.size() - base, cnt);
      for (int i = 0; i < cnt && base + i < rx_q.size(); i++) begin
         chk({tag, "_data"}, rx_q[base+i][31:0], i + 1);
         chk({tag, "_last"}, rx_q[base+i][32], (i == cnt - 1) ? 1 : 0);
      end
   endtask

   initial begin
      int base;
      int fd0;
      axis_rst_n = 1'b0;
      s_tvalid   = 1'b0;
      s_tdata    = '0;
      s_tlast    = 1'b0;
      m_tready   = 1'b0;
      frame_len  = 32'd0;
      err_clr    = 1'b0;
      #2;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_level", level, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_frame_done", frame_done, 0);
      tick();
      tick();
      #2 axis_rst_n = 1'b1;
      tick();
      chk("post_rst_s_tready", s_tready, 1);

      // Streaming: 600-beat frame with a sink that never stalls.
      frame_len = 32'd600;
      m_tready  = 1'b1;
      base = rx_q.size();
      fd0  = fd_cnt;
      mon_rdy = 1;
      for (int i = 1; i <= 600; i++) push(i, i == 600);
      idle(4);
      mon_rdy = 0;
      chk_rx("stream", base, 600);
      chk("stream_frame_done", fd_cnt - fd0, 1);
      chk("stream_len_err", len_err, 0);
      chk("stream_rdy_drops", rdy_drop, 0);

      // Backpressure: 10 beats into a depth-8 FIFO with the sink stalled.
      frame_len = 32'd10;
      m_tready  = 1'b0;
      base = rx_q.size();
      for (int i = 1; i <= 8; i++) push(i, 1'b0);
      chk("bp_level_full", level, 8);
      chk("bp_s_tready_low", s_tready, 0);
      s_tvalid = 1'b1;
      s_tdata  = 32'd9;
      tick(); tick(); tick();
      chk("bp_level_stall", level, 8);
      chk("bp_s_tready_stall", s_tready, 0);
      chk("bp_head_stable", m_tdata, 1);
      m_tready = 1'b1;
      push(9, 1'b0);
      push(10, 1'b1);
      idle(12);
      chk_rx("bp", base, 10);
      chk("bp_len_err", len_err, 0);

      // Simultaneous push and pop at and below full.
      m_tready = 1'b0;
      base = rx_q.size();
      for (int i = 1; i <= 8; i++) push(i, 1'b0);
      chk("sim_level_full", level, 8);
      s_tvalid = 1'b1;
      s_tdata  = 32'd9;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      tick();
      chk("sim_pop_only_level", level, 7);
      chk("sim_s_tready_up", s_tready, 1);
      tick();
      chk("sim_push_pop_level", level, 7);
      s_tdata = 32'd10;
      s_tlast = 1'b1;
      tick();
      chk("sim_push_pop_level2", level, 7);
      idle(12);
      chk_rx("sim", base, 10);
      chk("sim_len_err", len_err, 0);

      // Short frame: tlast on beat 4 of an expected 5.
      frame_len = 32'd5;
      fd0 = fd_cnt;
      for (int i = 1; i <= 3; i++) push(i, 1'b0);
      chk("short_len_err_b3", len_err, 0);
      push(4, 1'b1);
      chk("short_len_err_b4", len_err, 1);
      idle(2);
      chk("short_len_err_sticky", len_err, 1);
      pulse_clr();
      chk("short_len_err_clr", len_err, 0);
      for (int i = 1; i <= 5; i++) push(i, i == 5);
      idle(3);
      chk("good_len_err", len_err, 0);
      chk("good_frame_done", fd_cnt - fd0, 2);

      // Missing tlast: 4 beats against an expected 3.
      frame_len = 32'd3;
      push(1, 1'b0);
      push(2, 1'b0);
      chk("miss_len_err_b2", len_err, 0);
      push(3, 1'b0);
      chk("miss_len_err_b3", len_err, 1);
      push(4, 1'b0);
      idle(2);
      chk("miss_len_err_b4", len_err, 1);

      // Reset mid-operation: close the open frame, then leave 5 queued with counter at 2.
      m_tready = 1'b0;
      push(1, 1'b0);
      push(2, 1'b0);
      push(3, 1'b1);
      push(4, 1'b0);
      push(5, 1'b0);
      idle(1);
      chk("pre_rst_level", level, 5);
      chk("pre_rst_len_err", len_err, 1);
      #2 axis_rst_n = 1'b0;
      #1;
      chk("mid_rst_m_tvalid", m_tvalid, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_len_err", len_err, 0);
      chk("mid_rst_s_tready", s_tready, 0);
      tick();
      #2 axis_rst_n = 1'b1;
      tick();
      m_tready  = 1'b1;
      frame_len = 32'd3;
      base = rx_q.size();
      fd0  = fd_cnt;
      for (int i = 1; i <= 3; i++) push(i, i == 3);
      idle(4);
      chk_rx("fresh", base, 3);
      chk("fresh_len_err", len_err, 0);
      chk("fresh_frame_done", fd_cnt - fd0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
